// File: rtl/ee357_mc_pkg.sv
// Shared encodings for the EE357 multicycle controller: state codes, opcodes,
// and datapath mux/ALU select values.
package ee357_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } mc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ee357_mc_control.sv
// Moore controller for the EE357 multicycle datapath; one state register with
// separate next-state and output decode. FETCH ir_write/pc_write track mem_ready.
module ee357_mc_control
    import ee357_mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q <= STATE_W'(S_FETCH);
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Memory-wait states hold until the handshake; unused codes fall back to FETCH.
    always_comb begin
        state_d = STATE_W'(S_FETCH);
        case (state_q)
            STATE_W'(S_FETCH):     state_d = mem_ready ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
            STATE_W'(S_DECODE): begin
                case (opcode)
                    OP_LW, OP_SW: state_d = STATE_W'(S_MEM_ADDR);
                    OP_RTYPE:     state_d = STATE_W'(S_EXEC_R);
                    OP_BEQ:       state_d = STATE_W'(S_BRANCH);
                    OP_J:         state_d = STATE_W'(S_JUMP);
                    OP_ADDI:      state_d = STATE_W'(S_ADDI_EX);
                    default:      state_d = STATE_W'(S_FETCH);
                endcase
            end
            STATE_W'(S_MEM_ADDR): begin
                if (opcode == OP_LW) begin
                    state_d = STATE_W'(S_MEM_READ);
                end else if (opcode == OP_SW) begin
                    state_d = STATE_W'(S_MEM_WRITE);
                end else begin
                    state_d = STATE_W'(S_FETCH);
                end
            end
            STATE_W'(S_MEM_READ):  state_d = mem_ready ? STATE_W'(S_MEM_WB) : STATE_W'(S_MEM_READ);
            STATE_W'(S_MEM_WRITE): state_d = mem_ready ? STATE_W'(S_FETCH) : STATE_W'(S_MEM_WRITE);
            STATE_W'(S_EXEC_R):    state_d = STATE_W'(S_R_WB);
            STATE_W'(S_ADDI_EX):   state_d = STATE_W'(S_ADDI_WB);
            default:               state_d = STATE_W'(S_FETCH);
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state_q)
            STATE_W'(S_FETCH): begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            STATE_W'(S_DECODE): begin
                alu_src_b  = SRCB_IMM_SHL;
                illegal_op = !is_legal_op(opcode);
            end
            STATE_W'(S_MEM_ADDR): begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            STATE_W'(S_MEM_READ): begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            STATE_W'(S_MEM_WB): begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            STATE_W'(S_MEM_WRITE): begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            STATE_W'(S_EXEC_R): begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            STATE_W'(S_R_WB): begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            STATE_W'(S_BRANCH): begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_BRANCH;
                instr_done    = 1'b1;
            end
            STATE_W'(S_JUMP): begin
                pc_write   = 1'b1;
                pc_source  = PC_JUMP;
                instr_done = 1'b1;
            end
            STATE_W'(S_ADDI_EX): begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            STATE_W'(S_ADDI_WB): begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ee357_mc_control.sv
// Scoreboard bench for ee357_mc_control: per-cycle expected state/controls are
// queued as stimulus is driven and compared on the falling edge.
module tb_ee357_mc_control;

    logic       sys_clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    ee357_mc_control #(.STATE_W(4)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .iord         (iord),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .instr_done   (instr_done),
        .illegal_op   (illegal_op),
        .state        (state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [17:0] ctrl;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] obs_ctrl();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, instr_done, illegal_op};
    endfunction

    // Reference control table, written from the state descriptions.
    function automatic logic [17:0] model(input logic [3:0] st, input logic mr, input logic [5:0] op);
        logic pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, sa, dn, ill;
        logic [1:0] sb, ao, ps;
        {pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, sa, dn, ill} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  begin sb = 2'b11;
                         ill = !(op inside {6'b000000, 6'b000010, 6'b000100,
                                            6'b001000, 6'b100011, 6'b101011}); end
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin mrd = 1; io = 1; end
            4'd4:  begin rw = 1; m2r = 1; dn = 1; end
            4'd5:  begin mwr = 1; io = 1; dn = mr; end
            4'd6:  begin sa = 1; ao = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; dn = 1; end
            4'd8:  begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; dn = 1; end
            4'd9:  begin pcw = 1; ps = 2'b10; dn = 1; end
            4'd10: begin sa = 1; sb = 2'b10; end
            4'd11: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps, dn, ill};
    endfunction

    always @(negedge sys_clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.tag, "/state"}, 32'(state), 32'(e.st));
            chk({e.tag, "/ctrl"}, 32'(obs_ctrl()), 32'(e.ctrl));
            chk({e.tag, "/excl"}, {30'd0, mem_write & reg_write, mem_read & mem_write}, 32'd0);
        end
    end

    // Drive one cycle: set inputs, queue the expectation, advance past the next rising edge.
    task automatic step(input string tag, input logic mr, input logic [3:0] st);
        exp_t e;
        mem_ready = mr;
        e.tag  = tag;
        e.st   = st;
        e.ctrl = model(st, mr, opcode);
        sb_q.push_back(e);
        @(negedge sys_clk);
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        #1;
        step("rst0", 1'b1, 4'd0);
        step("rst1", 1'b1, 4'd0);
        reset = 1'b1;

        opcode = 6'b100011;
        step("lw", 1, 4'd0); step("lw", 1, 4'd1); step("lw", 1, 4'd2);
        step("lw", 1, 4'd3); step("lw", 1, 4'd4);

        opcode = 6'b101011;
        step("sw", 1, 4'd0); step("sw", 1, 4'd1); step("sw", 1, 4'd2);
        step("sw_wait", 0, 4'd5); step("sw_wait", 0, 4'd5); step("sw_done", 1, 4'd5);

        opcode = 6'b000100;
        step("beq", 1, 4'd0); step("beq", 1, 4'd1); step("beq", 1, 4'd8);
        opcode = 6'b000010;
        step("j", 1, 4'd0); step("j", 1, 4'd1); step("j", 1, 4'd9);

        opcode = 6'b000000;
        step("rtype", 1, 4'd0); step("rtype", 1, 4'd1);
        step("rtype", 1, 4'd6); step("rtype", 1, 4'd7);

        opcode = 6'b001000;
        step("addi", 1, 4'd0); step("addi", 1, 4'd1);
        step("addi", 1, 4'd10); step("addi", 1, 4'd11);

        opcode = 6'b111111;
        step("illegal", 1, 4'd0); step("illegal", 1, 4'd1);

        opcode = 6'b100011;
        step("lw_fwait", 0, 4'd0); step("lw_f", 1, 4'd0); step("lw_f", 1, 4'd1);
        step("lw_f", 1, 4'd2); step("lw_rwait", 0, 4'd3); step("lw_r", 1, 4'd3);
        step("lw_r", 1, 4'd4);

        // Reset asserted between edges while in EXEC_R.
        opcode = 6'b000000;
        step("rst_mid", 1, 4'd0); step("rst_mid", 1, 4'd1);
        begin
            exp_t e;
            e.tag = "rst_mid_exec"; e.st = 4'd6; e.ctrl = model(4'd6, 1'b1, opcode);
            sb_q.push_back(e);
        end
        @(negedge sys_clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst/state", 32'(state), 32'd0);
        chk("async_rst/ctrl", 32'(obs_ctrl()), 32'(model(4'd0, 1'b1, opcode)));
        @(posedge sys_clk);
        #1;
        reset = 1'b1;

        opcode = 6'b001000;
        step("post_rst", 1, 4'd0); step("post_rst", 1, 4'd1);
        step("post_rst", 1, 4'd10); step("post_rst", 1, 4'd11);
        step("post_rst", 1, 4'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
